// File: rtl/clk_en_synth_pkg.sv
// clk_en_synth_pkg
// Shared types and helpers for the clock-enable synthesiser:
//   state_t   - top-level FSM state encoding
//   MAX_CH    - largest supported channel count
//   ch_width  - index width for a count of items, never narrower than 1 bit
package clk_en_synth_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  // Width needed to index n items; a single item still gets one bit so that
  // ports and counters never collapse to zero width.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_synth_nco.sv
// clk_en_synth_nco
// One phase-accumulator NCO channel.
//   refclk  - clock, rising edge
//   rst     - asynchronous active-high reset
//   load    - load the accumulator with phase (outputs restart from phase)
//   adv     - add step to the accumulator, register the carry as clk_en
//   step    - phase increment
//   phase   - start phase
//   clk_en  - one-cycle pulse for every accumulator wrap
//   clk_sq  - accumulator MSB (square wave)
// With neither load nor adv the channel is quiet: outputs low, accumulator
// parked on phase.
module clk_en_synth_nco #(
  parameter int ACC_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [ACC_W-1:0] step,
  input  logic [ACC_W-1:0] phase,
  output logic             clk_en,
  output logic             clk_sq
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Extra top bit of the sum is the wrap carry that becomes the enable pulse.
  assign sum = {1'b0, acc} + {1'b0, step};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      clk_en <= 1'b0;
      clk_sq <= 1'b0;
    end else if (load) begin
      acc    <= phase;
      clk_en <= 1'b0;
      clk_sq <= phase[ACC_W-1];
    end else if (adv) begin
      acc    <= sum[ACC_W-1:0];
      clk_en <= sum[ACC_W];
      clk_sq <= sum[ACC_W-1];
    end else begin
      acc    <= phase;
      clk_en <= 1'b0;
      clk_sq <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_synth.sv
// clk_en_synth
// Multi-channel clock-enable synthesiser. Holds the run/align/settle FSM,
// the settle counter, per-channel shadow step/phase registers and the
// configuration decode; one clk_en_synth_nco per channel does the counting.
//   refclk     - sole clock
//   rst        - asynchronous active-high reset
//   run        - high to synthesise, low to park in IDLE
//   cfg_valid  - configuration write request
//   cfg_ready  - low only during ALIGN and while in reset
//   cfg_ch     - target channel (out-of-range writes are swallowed)
//   cfg_step   - phase increment for the target channel
//   cfg_phase  - start phase for the target channel
//   clk_en     - per-channel one-cycle enable pulses
//   clk_sq     - per-channel square waves
//   locked     - configuration has been stable for LOCK_CYCLES cycles
module clk_en_synth
  import clk_en_synth_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int ACC_W       = 16,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_step,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  localparam int CNT_W = ch_width(LOCK_CYCLES);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("clk_en_synth: NUM_CH must be in 1..%0d", MAX_CH);
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("clk_en_synth: LOCK_CYCLES must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [ACC_W-1:0] step_r  [NUM_CH];
  logic [ACC_W-1:0] phase_r [NUM_CH];

  logic ch_ok;
  logic wr_acc;
  logic wr_hit;
  logic running;
  logic nco_load;
  logic nco_adv;

  // When CH_W exactly covers NUM_CH every index is legal; otherwise compare,
  // which avoids a constant-true comparison in the power-of-two case.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (cfg_ch < CH_W'(NUM_CH));
  end

  assign cfg_ready = !rst && (state != ST_ALIGN);
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_hit    = wr_acc && ch_ok;
  assign running   = (state == ST_SETTLE) || (state == ST_LOCKED);

  // The NCOs are steered by the state this edge is leaving and the decision
  // taken at it, so they go quiet on the same edge the FSM enters ALIGN or
  // IDLE and outputs read 0 throughout those states.
  assign nco_load  = run && (state == ST_ALIGN);
  assign nco_adv   = run && running && !wr_hit;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      // NOTE: the shadow arrays are reset as well; a reset mid-run must leave
      // every channel silent, so these cannot map to reset-less RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        step_r[i]  <= '0;
        phase_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit && (cfg_ch == CH_W'(i))) begin
          step_r[i]  <= cfg_step;
          phase_r[i] <= cfg_phase;
        end
      end

      locked <= 1'b0;
      if (!run) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ALIGN;
          ST_ALIGN: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (wr_hit) begin
              state <= ST_ALIGN;
            end else if (settle_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (wr_hit) state  <= ST_ALIGN;
            else        locked <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_nco
    clk_en_synth_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .refclk (refclk),
      .rst    (rst),
      .load   (nco_load),
      .adv    (nco_adv),
      .step   (step_r[i]),
      .phase  (phase_r[i]),
      .clk_en (clk_en[i]),
      .clk_sq (clk_sq[i])
    );
  end

endmodule

// File: tb/tb_clk_en_synth.sv
// tb_clk_en_synth
// Self-checking bench for clk_en_synth. Three channels are instantiated so
// that cfg_ch is two bits wide and index 3 is a genuinely out-of-range
// write. The reference model tracks only the run mode and the number of
// increments since the last alignment; channel outputs are then computed in
// closed form as phase + n*step.
module tb_clk_en_synth;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              run;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_step;
  logic [ACC_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_sq;
  logic              locked;

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  clk_en_synth #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_step  (cfg_step),
    .cfg_phase (cfg_phase),
    .clk_en    (clk_en),
    .clk_sq    (clk_sq),
    .locked    (locked)
  );

  // Reference model: mode 0 = parked, 1 = aligning, 2 = running with m_n
  // increments applied since alignment.
  longint m_step  [NUM_CH];
  longint m_phase [NUM_CH];
  int     m_mode;
  longint m_n;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_step[i]  = 0;
      m_phase[i] = 0;
    end
    m_mode = 0;
    m_n    = 0;
  endtask

  // Applies one rising edge using the inputs that were stable before it.
  task automatic model_edge();
    bit hit;
    hit = cfg_valid && (m_mode != 1) && (int'(cfg_ch) < NUM_CH);
    if (hit) begin
      m_step[cfg_ch]  = longint'(cfg_step);
      m_phase[cfg_ch] = longint'(cfg_phase);
    end
    if (!run)             m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      m_mode = 2;
      m_n    = 0;
    end
    else if (hit)         m_mode = 1;
    else                  m_n++;
  endtask

  function automatic logic [NUM_CH-1:0] exp_en();
    logic [NUM_CH-1:0] r = '0;
    if (m_mode == 2 && m_n > 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        longint v = m_phase[i] + m_n * m_step[i];
        // A pulse follows every increment that crossed a multiple of 2^ACC_W.
        if ((v >> ACC_W) != ((v - m_step[i]) >> ACC_W)) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_sq();
    logic [NUM_CH-1:0] r = '0;
    if (m_mode == 2) begin
      for (int i = 0; i < NUM_CH; i++) begin
        longint v = m_phase[i] + m_n * m_step[i];
        r[i] = v[ACC_W-1];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_clk_en"}, 32'(clk_en), 32'(exp_en()));
    check({tag, "_clk_sq"}, 32'(clk_sq), 32'(exp_sq()));
    check({tag, "_locked"}, 32'(locked), 32'(m_mode == 2 && m_n >= LOCK_CYCLES));
    check({tag, "_ready"},  32'(cfg_ready), 32'(!rst && m_mode != 1));
  endtask

  task automatic tick(input string tag);
    @(posedge refclk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Holds a write until the model says it was accepted (at most 4 cycles).
  task automatic wr(input string tag, input logic [CH_W-1:0] ch,
                    input logic [ACC_W-1:0] step, input logic [ACC_W-1:0] phase);
    bit taken;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_step  = step;
    cfg_phase = phase;
    for (int t = 0; t < 4; t++) begin
      taken = (m_mode != 1);
      tick(tag);
      if (taken) break;
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_step  = '0;
    cfg_phase = '0;
    model_reset();

    #12;
    compare_all("in_reset");
    @(negedge refclk);
    rst = 1'b0;
    #1;
    compare_all("after_reset");
    repeat (20) tick("idle");

    // Half-rate channel from defaults; lock and first pulse timing.
    wr("wr_half", 2'd0, 16'h8000, 16'h0000);
    run = 1'b1;
    repeat (30) tick("half_rate");

    // Quarter-rate pair half a period apart (each write realigns).
    wr("wr_q0", 2'd0, 16'h4000, 16'h0000);
    wr("wr_q1", 2'd1, 16'h4000, 16'h8000);
    repeat (40) tick("quarter");

    // Reprogram ch1 while locked: ALIGN, relock, eighth rate.
    wr("wr_eighth", 2'd1, 16'h2000, 16'h1000);
    repeat (40) tick("eighth");

    // Out-of-range write while locked is swallowed.
    wr("wr_bad_ch", 2'd3, 16'h1234, 16'h4321);
    repeat (10) tick("bad_ch");

    // run falls during an accepted write: shadow updated, state parked.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_step  = 16'h1000;
    cfg_phase = 16'h8000;
    run       = 1'b0;
    tick("run_drop_wr");
    cfg_valid = 1'b0;
    repeat (5) tick("parked");
    run = 1'b1;
    repeat (30) tick("rerun");

    // Asynchronous reset mid-LOCKED clears outputs without a clock edge.
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge refclk);
    rst = 1'b0;
    repeat (30) tick("post_rst_silent");

    // Random traffic, including step 0, half rate, full scale and bad indices.
    for (int k = 0; k < 400; k++) begin
      run       = ($urandom_range(0, 24) != 0);
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_step = 16'h0000;
        1:       cfg_step = 16'h8000;
        2:       cfg_step = 16'hFFFF;
        default: cfg_step = ACC_W'($urandom_range(0, 16'hFFFF));
      endcase
      cfg_phase = ACC_W'($urandom_range(0, 16'hFFFF));
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
